// File: rtl/scan_chain_pkg.sv
// Shared types for the scan chain master: sequencer states, scan-clock sub-phases, chain length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_chain_pkg;

  // Total bit count of the generated chain this driver is built for.
  localparam int SCAN_CHAIN_LENGTH = 87;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    DONE
  } state_e;

  // One scan pulse pair is P-high, gap, N-high, gap.
  typedef enum logic [1:0] {
    PH_P,
    PH_G1,
    PH_N,
    PH_G2
  } subphase_e;

  function automatic subphase_e next_subphase(input subphase_e ph);
    subphase_e nxt;
    case (ph)
      PH_P:    nxt = PH_G1;
      PH_G1:   nxt = PH_N;
      PH_N:    nxt = PH_G2;
      default: nxt = PH_P;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Two-phase non-overlapping scan clock generator; pairs run back to back while go is high.
// Latency: SClkP rises the cycle after go is first seen; each pair lasts 4*PHASE_CYCLES cycles.
// Backpressure: none; go is re-examined only at the end of a pair, so a started pair always completes.
module scan_phase_gen
  import scan_chain_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic go,
  output logic SClkP,
  output logic SClkN,
  output logic sample_strobe,
  output logic pair_done
);

  localparam int PC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_CYCLES - 1);

  logic            run_q, run_d;
  subphase_e       ph_q, ph_d;
  logic [PC_W-1:0] cnt_q, cnt_d;
  logic            sclkp_q, sclkn_q;

  // Strobes mark the final cycle of N-high and of the trailing gap.
  assign sample_strobe = run_q && (ph_q == PH_N) && (cnt_q == PC_LAST);
  assign pair_done     = run_q && (ph_q == PH_G2) && (cnt_q == PC_LAST);
  assign SClkP         = sclkp_q;
  assign SClkN         = sclkn_q;

  // Prescaler and sub-phase sequencing; a new pair starts only if go is still high.
  always_comb begin
    run_d = run_q;
    ph_d  = ph_q;
    cnt_d = cnt_q;
    if (!run_q) begin
      if (go) begin
        run_d = 1'b1;
        ph_d  = PH_P;
        cnt_d = '0;
      end
    end else if (cnt_q != PC_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      if (ph_q == PH_G2) begin
        run_d = go;
        ph_d  = PH_P;
      end else begin
        ph_d = next_subphase(ph_q);
      end
    end
  end

  // Clocks are registered from the next sub-phase so they change glitch-free on Clk.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_q   <= 1'b0;
      ph_q    <= PH_P;
      cnt_q   <= '0;
      sclkp_q <= 1'b0;
      sclkn_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sclkp_q <= run_d && (ph_d == PH_P);
      sclkn_q <= run_d && (ph_d == PH_N);
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Scan chain master: optional capture, CHAIN_LENGTH-bit shift (LSB first), optional SUpdate pulse.
// Latency: (DoCapture+CHAIN_LENGTH)*4*PHASE_CYCLES + DoUpdate*2*PHASE_CYCLES + 1 cycles accept-to-Done.
// Backpressure: Ready low from the cycle after accept through Done; Start while not Ready is dropped.
module scan_chain_driver
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LENGTH = SCAN_CHAIN_LENGTH,
  parameter int PHASE_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    DoCapture,
  input  logic                    DoUpdate,
  input  logic [CHAIN_LENGTH-1:0] WrData,
  output logic                    Ready,
  output logic                    Done,
  output logic [CHAIN_LENGTH-1:0] RdData,
  output logic                    SClkP,
  output logic                    SClkN,
  output logic                    SReset,
  output logic                    SEnable,
  output logic                    SUpdate,
  output logic                    SIn,
  input  logic                    SOut
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int UPD_W = $clog2(2 * PHASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CHAIN_LENGTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [UPD_W-1:0] UPD_HALF = UPD_W'(PHASE_CYCLES);
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(2 * PHASE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [CHAIN_LENGTH-1:0] shreg_q, shreg_d;
  logic [CHAIN_LENGTH-1:0] rd_q, rd_d;
  logic [UPD_W-1:0]        updcnt_q, updcnt_d;
  logic                    upd_q, upd_d;
  logic                    sin_q, sin_d;
  logic                    ready_q, done_q, senable_q, supdate_q, sreset_q;
  logic                    go, sample_strobe, pair_done;

  scan_phase_gen #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase (
    .Clk          (Clk),
    .Reset        (Reset),
    .go           (go),
    .SClkP        (SClkP),
    .SClkN        (SClkN),
    .sample_strobe(sample_strobe),
    .pair_done    (pair_done)
  );

  // Pulse pairs are wanted exactly while the sequencer is (or is about to be) capturing or shifting.
  assign go = (state_d == CAPTURE) || (state_d == SHIFT);

  assign Ready   = ready_q;
  assign Done    = done_q;
  assign RdData  = rd_q;
  assign SReset  = sreset_q;
  assign SEnable = senable_q;
  assign SUpdate = supdate_q;
  assign SIn     = sin_q;

  // Sequencer next state, bit counter, shift register and serial data.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    rd_d     = rd_q;
    updcnt_d = updcnt_q;
    upd_d    = upd_q;
    sin_d    = sin_q;
    case (state_q)
      IDLE: begin
        if (Start && ready_q) begin
          shreg_d  = WrData;
          sin_d    = WrData[0];
          upd_d    = DoUpdate;
          bitcnt_d = CNT_INIT;
          state_d  = DoCapture ? CAPTURE : SHIFT;
        end
      end
      CAPTURE: begin
        if (pair_done) state_d = SHIFT;
      end
      SHIFT: begin
        // SOut enters at the top; the new LSB is presented on SIn during the trailing gap.
        if (sample_strobe) begin
          shreg_d                 = shreg_q >> 1;
          shreg_d[CHAIN_LENGTH-1] = SOut;
          sin_d                   = shreg_d[0];
        end
        if (pair_done) begin
          bitcnt_d = bitcnt_q - 1'b1;
          updcnt_d = '0;
          if (bitcnt_q == CNT_ONE) state_d = upd_q ? UPDATE : DONE;
        end
      end
      UPDATE: begin
        if (updcnt_q == UPD_LAST) state_d = DONE;
        else updcnt_d = updcnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE) rd_d = shreg_q;
  end

  // State and output registers; SReset simply follows Reset one cycle late.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      rd_q      <= '0;
      updcnt_q  <= '0;
      upd_q     <= 1'b0;
      sin_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      senable_q <= 1'b0;
      supdate_q <= 1'b0;
      sreset_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      rd_q      <= rd_d;
      updcnt_q  <= updcnt_d;
      upd_q     <= upd_d;
      sin_q     <= sin_d;
      ready_q   <= (state_d == IDLE);
      done_q    <= (state_d == DONE);
      senable_q <= (state_d == SHIFT);
      supdate_q <= (state_d == UPDATE) && (updcnt_d < UPD_HALF);
      sreset_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: two instances (PHASE_CYCLES 1 and 3) share one request stream.
// Each instance drives its own behavioural two-phase chain model (or a SIn->SOut loopback).
// Expected results are queued at request time and checked when each instance raises Done.
module tb_scan_chain_driver;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] wr;
    logic [N-1:0] rd;
    logic         cap;
    logic         upd;
  } req_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         do_cap = 1'b0;
  logic         do_upd = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         loopback = 1'b1;
  logic [N-1:0] cap_val = 8'h3C;

  logic         ready[2], done[2], sclkp[2], sclkn[2], sreset[2];
  logic         senable[2], supdate[2], sin[2], sout[2];
  logic [N-1:0] rd_data[2];

  // Chain model and monitor state, one slot per instance.
  logic [N-1:0] chain[2];
  logic         master[2];
  logic         pp[2], pn[2], pu[2], psin[2], active[2];
  logic [N-1:0] sin_rec[2];
  int           sh_pairs[2], cap_pairs[2], upd_pulses[2], acc_cyc[2], cur[2], nxt[2], done_cnt[2];

  req_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           exp_done = 0;
  int           cyc = 0;
  logic         rst_q = 1'b1;
  logic [N-1:0] chain_exp = '0;
  logic         chain_known = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  assign sout[0] = loopback ? sin[0] : chain[0][0];
  assign sout[1] = loopback ? sin[1] : chain[1][0];

  scan_chain_driver #(.CHAIN_LENGTH(N), .PHASE_CYCLES(1)) dut_a (
    .Clk(clk), .Reset(rst), .Start(start), .DoCapture(do_cap), .DoUpdate(do_upd),
    .WrData(wr_data), .Ready(ready[0]), .Done(done[0]), .RdData(rd_data[0]),
    .SClkP(sclkp[0]), .SClkN(sclkn[0]), .SReset(sreset[0]), .SEnable(senable[0]),
    .SUpdate(supdate[0]), .SIn(sin[0]), .SOut(sout[0])
  );

  scan_chain_driver #(.CHAIN_LENGTH(N), .PHASE_CYCLES(3)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start), .DoCapture(do_cap), .DoUpdate(do_upd),
    .WrData(wr_data), .Ready(ready[1]), .Done(done[1]), .RdData(rd_data[1]),
    .SClkP(sclkp[1]), .SClkN(sclkn[1]), .SReset(sreset[1]), .SEnable(senable[1]),
    .SUpdate(supdate[1]), .SIn(sin[1]), .SOut(sout[1])
  );

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL dut%0d %s: got %0h want %0h (cycle %0d)", g, name, act, exp_v, cyc);
    end
  endtask

  task automatic mon_step(input int g);
    int   pc;
    int   lat;
    req_t e;
    pc = (g == 0) ? 1 : 3;
    chk(g, "sreset_follows_reset", sreset[g], rst_q);
    if (rst_q) begin
      // Ready=1, everything else 0: {Ready,Done,P,N,En,Upd,SIn,RdData} = 15'h4000.
      chk(g, "reset_outputs", {ready[g], done[g], sclkp[g], sclkn[g], senable[g],
                               supdate[g], sin[g], rd_data[g]}, 32'h4000);
      active[g] = 1'b0;
    end else begin
      chk(g, "clk_overlap", (sclkp[g] && sclkn[g]) || (sclkp[g] && pn[g]) || (sclkn[g] && pp[g]), 0);
      if (sclkp[g] && !pp[g]) begin
        psin[g] = sin[g];
        if (senable[g]) begin
          sh_pairs[g]++;
          sin_rec[g] = {sin[g], sin_rec[g][N-1:1]};
        end else begin
          cap_pairs[g]++;
        end
      end
      if (sclkp[g] || sclkn[g]) chk(g, "sin_stable", sin[g], psin[g]);
      if (supdate[g] && !pu[g]) upd_pulses[g]++;
      // Chain: masters latch SIn on P, slaves advance when N falls; capture loads R cells on P.
      if (sclkp[g] && senable[g]) master[g] = sin[g];
      if (sclkp[g] && !senable[g]) chain[g] = cap_val;
      if (!sclkn[g] && pn[g] && senable[g]) chain[g] = {master[g], chain[g][N-1:1]};
      if (start && ready[g]) begin
        if (nxt[g] < exp_q.size()) begin
          cur[g]        = nxt[g];
          nxt[g]        = nxt[g] + 1;
          active[g]     = 1'b1;
          acc_cyc[g]    = cyc;
          sh_pairs[g]   = 0;
          cap_pairs[g]  = 0;
          upd_pulses[g] = 0;
          sin_rec[g]    = '0;
        end else begin
          chk(g, "unexpected_accept", nxt[g], exp_q.size());
        end
      end
      if (done[g]) begin
        if (!active[g]) begin
          chk(g, "unexpected_done", active[g], 1);
        end else begin
          e   = exp_q[cur[g]];
          lat = (int'(e.cap) + N) * 4 * pc + int'(e.upd) * 2 * pc + 1;
          chk(g, "latency", cyc - acc_cyc[g], lat);
          chk(g, "rd_data", rd_data[g], e.rd);
          chk(g, "sin_sequence", sin_rec[g], e.wr);
          chk(g, "shift_pairs", sh_pairs[g], N);
          chk(g, "capture_pairs", cap_pairs[g], e.cap);
          chk(g, "update_pulses", upd_pulses[g], e.upd);
          active[g] = 1'b0;
          done_cnt[g]++;
        end
      end
    end
    pp[g] = sclkp[g];
    pn[g] = sclkn[g];
    pu[g] = supdate[g];
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      chain[g] = '0; master[g] = 1'b0; pp[g] = 1'b0; pn[g] = 1'b0; pu[g] = 1'b0;
      psin[g] = 1'b0; active[g] = 1'b0; sin_rec[g] = '0; sh_pairs[g] = 0; cap_pairs[g] = 0;
      upd_pulses[g] = 0; acc_cyc[g] = 0; cur[g] = 0; nxt[g] = 0; done_cnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mon_step(g);
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(ready[0] && ready[1]) && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    chk(-1, "idle_wait", ready[0] && ready[1], 1);
  endtask

  // Reference model: the chain returns whatever it held (or captured, or the looped-back data),
  // and afterwards holds the written data.
  task automatic issue(input logic [N-1:0] w, input logic c, input logic u,
                       input logic lb, input logic [N-1:0] cv);
    logic [N-1:0] r;
    wait_idle();
    loopback = lb;
    cap_val  = cv;
    if (lb) r = w;
    else if (c) r = cv;
    else r = chain_exp;
    wr_data = w;
    do_cap  = c;
    do_upd  = u;
    start   = 1'b1;
    exp_q.push_back({w, r, c, u});
    exp_done++;
    chain_exp   = w;
    chain_known = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [N-1:0] w;
    logic         c, u, lb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Loopback, no capture, with update.
    issue(8'hA5, 1'b0, 1'b1, 1'b1, 8'h00);
    // Chain preloaded, capture first, no update.
    issue(8'($urandom), 1'b1, 1'b0, 1'b0, 8'h3C);

    // Start spammed while busy must be ignored.
    w = 8'($urandom);
    issue(w, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      do_cap  = 1'($urandom_range(0, 1));
      do_upd  = 1'($urandom_range(0, 1));
    end
    start = 1'b0;

    // Reset during the 4th shift pair of the fast instance, with an update pending.
    issue(8'($urandom), 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    exp_done--;
    chain_known = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(8'($urandom), 1'b1, 1'b1, 1'b0, 8'($urandom));

    // Random requests.
    for (int i = 0; i < 8; i++) begin
      w  = 8'($urandom);
      c  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      if (!chain_known && !lb) c = 1'b1;
      issue(w, c, u, lb, 8'($urandom));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk(0, "done_count", done_cnt[0], exp_done);
    chk(1, "done_count", done_cnt[1], exp_done);
    chk(0, "requests_accepted", nxt[0], exp_q.size());
    chk(1, "requests_accepted", nxt[1], exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
